// File: rtl/fifo_pkg.sv
// Shared pointer helpers for the dual-clock Gray-pointer FIFO.
package fifo_pkg;

  localparam int PTR_WIDTH_DEF = 3;
  localparam int DEPTH_DEF = 2 ** PTR_WIDTH_DEF;

  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

  // Gray value of the write pointer that means "exactly one lap ahead"
  function automatic logic [31:0] full_tgt(
    input logic [31:0] g,
    input int          w
  );
    return g ^ (32'd3 << (w - 2));
  endfunction

endpackage

// File: rtl/wptr_handler_gray2bin.sv
// Combinational Gray-to-binary decoder, prefix XOR from the MSB.
module gray2bin #(
  parameter int W = 4
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^(gray >> i);
  end

endmodule

// File: rtl/wptr_handler.sv
// Write pointer, full, level and almost-full for the async FIFO.
// Optional sticky overflow flag: WPTR_OVF_STICKY_EN.
module wptr_handler
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH = PTR_WIDTH_DEF,
  parameter int AF_THRESH = 6
) (
  input  logic                 wclk,
  input  logic                 wrst_n,
  input  logic                 w_en,
  input  logic [PTR_WIDTH:0]   g_rptr_sync,
  output logic [PTR_WIDTH:0]   b_wptr,
  output logic [PTR_WIDTH:0]   g_wptr,
  output logic                 full,
  output logic                 almost_full,
  output logic [PTR_WIDTH:0]   wlevel,
  output logic                 overflow,
  input  logic                 ovf_clr
);

  localparam int PW = PTR_WIDTH + 1;
  localparam logic [PW-1:0] AF = PW'(AF_THRESH);

  logic          w_acc;
  logic [PW-1:0] b_next;
  logic [PW-1:0] g_next;
  logic [PW-1:0] b_rptr_s;
  logic [PW-1:0] lvl_next;
  logic          full_next;

  gray2bin #(.W(PW)) u_g2b (
    .gray (g_rptr_sync),
    .bin  (b_rptr_s)
  );

  assign w_acc     = w_en & ~full;
  assign b_next    = b_wptr + PW'(w_acc);
  assign g_next    = PW'(bin2gray(32'(b_next)));
  assign full_next = (32'(g_next) ==
                      full_tgt(32'(g_rptr_sync), PW));
  assign lvl_next  = b_next - b_rptr_s;

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      b_wptr      <= '0;
      g_wptr      <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wlevel      <= '0;
    end else begin
      b_wptr      <= b_next;
      g_wptr      <= g_next;
      full        <= full_next;
      almost_full <= (lvl_next >= AF);
      wlevel      <= lvl_next;
    end
  end

`ifdef WPTR_OVF_STICKY_EN
  logic ovf_q;

  // set has priority over clear
  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      ovf_q <= 1'b0;
    end else if (w_en & full) begin
      ovf_q <= 1'b1;
    end else if (ovf_clr) begin
      ovf_q <= 1'b0;
    end
  end

  assign overflow = ovf_q;
`else
  logic unused_ovf_clr;

  assign unused_ovf_clr = ovf_clr;
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_handler.sv
// Directed self-checking bench for wptr_handler.
module tb_wptr_handler;

  logic       wclk = 1'b0;
  logic       wrst_n;
  logic       w_en;
  logic [3:0] g_rptr_sync;
  logic [3:0] b_wptr;
  logic [3:0] g_wptr;
  logic       full;
  logic       almost_full;
  logic [3:0] wlevel;
  logic       overflow;
  logic       ovf_clr;

  int n_chk = 0;
  int n_fail = 0;

  int b_m;
  int r_m;
  int lvl;
  bit ovf_en;

  wptr_handler #(.PTR_WIDTH(3), .AF_THRESH(6)) dut (
    .wclk        (wclk),
    .wrst_n      (wrst_n),
    .w_en        (w_en),
    .g_rptr_sync (g_rptr_sync),
    .b_wptr      (b_wptr),
    .g_wptr      (g_wptr),
    .full        (full),
    .almost_full (almost_full),
    .wlevel      (wlevel),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr)
  );

  always #5 wclk = ~wclk;

  task automatic tick();
    @(posedge wclk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] gray4(input int b);
    logic [3:0] v;
    v = 4'(b);
    return v ^ (v >> 1);
  endfunction

  initial begin
`ifdef WPTR_OVF_STICKY_EN
    ovf_en = 1'b1;
`else
    ovf_en = 1'b0;
`endif
    wrst_n = 1'b0;
    w_en = 1'b1;
    g_rptr_sync = 4'b0000;
    ovf_clr = 1'b0;

    // reset with writes held
    tick();
    chk("rst_b", 32'(b_wptr), 0);
    chk("rst_g", 32'(g_wptr), 0);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_lvl", 32'(wlevel), 0);
    chk("rst_ovf", 32'(overflow), 0);
    tick();
    chk("rst2_b", 32'(b_wptr), 0);

    // fill to full
    wrst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      chk("fill_b", 32'(b_wptr), 32'(i));
      chk("fill_lvl", 32'(wlevel), 32'(i));
      chk("fill_af", 32'(almost_full), 32'(i >= 6));
      chk("fill_full", 32'(full), 32'(i == 8));
    end
    chk("full_g", 32'(g_wptr), 32'(4'b1100));

    // writes while full are dropped
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("drop_b", 32'(b_wptr), 32'(4'b1000));
      chk("drop_full", 32'(full), 1);
      chk("drop_ovf", 32'(overflow), 32'(ovf_en));
    end
    ovf_clr = 1'b1;
    tick();
    chk("ovf_setwins", 32'(overflow), 32'(ovf_en));
    w_en = 1'b0;
    tick();
    chk("ovf_clr", 32'(overflow), 0);
    ovf_clr = 1'b0;

    // reader advances to binary 2
    g_rptr_sync = 4'b0011;
    tick();
    chk("rd_full", 32'(full), 0);
    chk("rd_lvl", 32'(wlevel), 6);
    chk("rd_af", 32'(almost_full), 1);
    w_en = 1'b1;
    tick();
    chk("rd_w_lvl", 32'(wlevel), 7);
    chk("rd_w_b", 32'(b_wptr), 32'(4'b1001));
    chk("rd_w_full", 32'(full), 0);

    // catch the reader up to two behind
    w_en = 1'b0;
    b_m = 9;
    for (r_m = 3; r_m <= 7; r_m++) begin
      g_rptr_sync = gray4(r_m);
      tick();
      chk("catch_lvl", 32'(wlevel), 32'(b_m - r_m));
    end
    r_m = 7;

    // streaming with wrap-around
    w_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      b_m = (b_m + 1) % 16;
      r_m = (r_m + 1) % 16;
      g_rptr_sync = gray4(r_m);
      tick();
      lvl = (b_m - r_m + 16) % 16;
      chk("wrap_b", 32'(b_wptr), 32'(b_m));
      chk("wrap_g", 32'(g_wptr), 32'(gray4(b_m)));
      chk("wrap_lvl", 32'(wlevel), 32'(lvl));
      chk("wrap_full", 32'(full), 0);
      chk("wrap_af", 32'(almost_full), 0);
    end

    // reset mid-burst
    wrst_n = 1'b0;
    g_rptr_sync = 4'b0000;
    tick();
    wrst_n = 1'b1;
    for (int i = 1; i <= 5; i++) tick();
    chk("pre_b", 32'(b_wptr), 5);
    chk("pre_af", 32'(almost_full), 0);
    wrst_n = 1'b0;
    tick();
    chk("mid_b", 32'(b_wptr), 0);
    chk("mid_g", 32'(g_wptr), 0);
    chk("mid_lvl", 32'(wlevel), 0);
    chk("mid_full", 32'(full), 0);
    chk("mid_af", 32'(almost_full), 0);
    chk("mid_ovf", 32'(overflow), 0);
    wrst_n = 1'b1;
    tick();
    chk("post_b", 32'(b_wptr), 1);
    chk("post_g", 32'(g_wptr), 1);
    chk("post_lvl", 32'(wlevel), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
